// File: rtl/multi_rate_serial_channel.sv
// Multi-rate serializer: emits a programmable bit pattern where every bit picks one of RATE_NUM periods.
// One-shot / continuous / repeat-N modes, graceful stop, double-buffered config applied at pattern boundaries.
module multi_rate_serial_channel #(
    parameter int DATA_BIT     = 64,
    parameter int LEN_BIT      = 6,
    parameter int RATE_NUM     = 4,
    parameter int RATE_SEL_BIT = 2,
    parameter int PERIOD_BIT   = 8,
    parameter int REPEAT_BIT   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cfg_we_i,
    input  logic [DATA_BIT-1:0]              cfg_data_i,
    input  logic [DATA_BIT*RATE_SEL_BIT-1:0] cfg_rate_i,
    input  logic [LEN_BIT-1:0]               cfg_len_i,
    input  logic [1:0]                       cfg_mode_i,
    input  logic                             cfg_idle_i,
    input  logic [REPEAT_BIT-1:0]            cfg_repeat_i,
    input  logic [RATE_NUM*PERIOD_BIT-1:0]   period_i,
    input  logic                             start_i,
    input  logic                             stop_i,
    output logic                             serial_o,
    output logic                             busy_o,
    output logic                             bit_tick_o,
    output logic                             done_tick_o,
    output logic                             cfg_pending_o
);

    localparam logic [1:0] MODE_CONT = 2'b01;
    localparam logic [1:0] MODE_REP  = 2'b10;

    typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;

    state_t r_state, w_state_nxt;

    // Shadow (written by the decoder) and active (driving the output) configuration
    logic [DATA_BIT-1:0]              r_sh_data,   r_act_data;
    logic [DATA_BIT*RATE_SEL_BIT-1:0] r_sh_rate,   r_act_rate;
    logic [LEN_BIT-1:0]               r_sh_len,    r_act_len;
    logic [1:0]                       r_sh_mode,   r_act_mode;
    logic                             r_sh_idle,   r_act_idle;
    logic [REPEAT_BIT-1:0]            r_sh_repeat, r_act_repeat;
    logic                             r_pending;

    logic [LEN_BIT-1:0]    r_bit_idx;
    logic [REPEAT_BIT-1:0] r_rep_cnt;
    logic [PERIOD_BIT-1:0] r_cnt;
    logic [PERIOD_BIT-1:0] r_period;
    logic                  r_stop;
    logic                  r_serial;
    logic                  r_done;

    logic                             w_start, w_bit_end, w_pat_end, w_finish, w_wrap, w_copy;
    logic [REPEAT_BIT-1:0]            w_rep_max;
    logic [LEN_BIT-1:0]               w_len_clamped;
    logic [LEN_BIT-1:0]               w_nxt_idx;
    logic [DATA_BIT-1:0]              w_nxt_data;
    logic [DATA_BIT*RATE_SEL_BIT-1:0] w_nxt_rate;
    logic [PERIOD_BIT-1:0]            w_nxt_period;

    function automatic logic [PERIOD_BIT-1:0] f_period(
        input logic [DATA_BIT*RATE_SEL_BIT-1:0] rate,
        input logic [LEN_BIT-1:0]               idx,
        input logic [RATE_NUM*PERIOD_BIT-1:0]   tab
    );
        logic [RATE_SEL_BIT-1:0] sel;
        logic [PERIOD_BIT-1:0]   p;
        sel = rate[idx*RATE_SEL_BIT +: RATE_SEL_BIT];
        p   = tab[sel*PERIOD_BIT +: PERIOD_BIT];
        return (p == '0) ? PERIOD_BIT'(1) : p;
    endfunction

    assign w_rep_max     = (r_act_repeat == '0) ? REPEAT_BIT'(1) : r_act_repeat;
    assign w_len_clamped = (int'(cfg_len_i) >= DATA_BIT) ? LEN_BIT'(DATA_BIT - 1) : cfg_len_i;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bit_end   = 1'b0;
        w_pat_end   = 1'b0;
        w_finish    = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_bit_end = (r_cnt == r_period - 1'b1);
                w_pat_end = w_bit_end && (r_bit_idx == r_act_len);
                if (w_pat_end) begin
                    w_finish = r_stop || stop_i
                            || ((r_act_mode != MODE_CONT) && (r_act_mode != MODE_REP))
                            || ((r_act_mode == MODE_REP) && (r_rep_cnt >= w_rep_max));
                    if (w_finish) w_state_nxt = ST_IDLE;
                    else          w_wrap      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow always equals active unless pending, so copying unconditionally is equivalent.
    assign w_copy       = w_start || w_wrap;
    assign w_nxt_idx    = w_copy ? '0 : r_bit_idx + 1'b1;
    assign w_nxt_data   = w_copy ? r_sh_data : r_act_data;
    assign w_nxt_rate   = w_copy ? r_sh_rate : r_act_rate;
    assign w_nxt_period = f_period(w_nxt_rate, w_nxt_idx, period_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sh_data   <= '0;
            r_sh_rate   <= '0;
            r_sh_len    <= '0;
            r_sh_mode   <= '0;
            r_sh_idle   <= 1'b0;
            r_sh_repeat <= '0;
            r_pending   <= 1'b0;
        end else if (cfg_we_i) begin
            r_sh_data   <= cfg_data_i;
            r_sh_rate   <= cfg_rate_i;
            r_sh_len    <= w_len_clamped;
            r_sh_mode   <= cfg_mode_i;
            r_sh_idle   <= cfg_idle_i;
            r_sh_repeat <= cfg_repeat_i;
            r_pending   <= 1'b1;
        end else if (w_copy) begin
            r_pending   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_act_data   <= '0;
            r_act_rate   <= '0;
            r_act_len    <= '0;
            r_act_mode   <= '0;
            r_act_idle   <= 1'b0;
            r_act_repeat <= '0;
            r_bit_idx    <= '0;
            r_rep_cnt    <= '0;
            r_cnt        <= '0;
            r_period     <= PERIOD_BIT'(1);
            r_stop       <= 1'b0;
            r_serial     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_copy) begin
                r_act_data   <= r_sh_data;
                r_act_rate   <= r_sh_rate;
                r_act_len    <= r_sh_len;
                r_act_mode   <= r_sh_mode;
                r_act_idle   <= r_sh_idle;
                r_act_repeat <= r_sh_repeat;
            end
            case (r_state)
                ST_IDLE: begin
                    r_stop   <= 1'b0;
                    r_serial <= r_act_idle;
                    if (w_start) begin
                        r_bit_idx <= '0;
                        r_cnt     <= '0;
                        r_rep_cnt <= REPEAT_BIT'(1);
                        r_period  <= w_nxt_period;
                        r_serial  <= w_nxt_data[w_nxt_idx];
                    end
                end
                ST_RUN: begin
                    if (stop_i) r_stop <= 1'b1;
                    if (!w_bit_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_finish) begin
                        r_serial <= r_act_idle;
                        r_done   <= 1'b1;
                        r_stop   <= 1'b0;
                    end else begin
                        r_cnt     <= '0;
                        r_bit_idx <= w_nxt_idx;
                        r_period  <= w_nxt_period;
                        r_serial  <= w_nxt_data[w_nxt_idx];
                        if (w_wrap && (r_act_mode == MODE_REP)) r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                end
                default: r_serial <= 1'b0;
            endcase
        end
    end

    assign serial_o      = r_serial;
    assign busy_o        = (r_state == ST_RUN);
    assign bit_tick_o    = w_bit_end;
    assign done_tick_o   = r_done;
    assign cfg_pending_o = r_pending;

endmodule
